memoria_loader: RTL and testbench
=================================

Name: memoria_loader

Overview:
- Write-side initiator for the 32-bit word memory: takes a byte stream from a host link (UART receiver or testbench) and writes it into the memory as a program image.
- Drives the memory's data, address and write-enable inputs while the processor is held off.
- Sits between the host link and the memory's write port. `busy` is used by the top level to stall the processor; `done` releases it.

Parameters:
- DATA_W, 32, memory word width (fixed at 4 bytes per word).
- ADDR_W, 10, memory address width.
- DEPTH, 128, number of implemented memory words; the upper bound for any load.

Ports:
- clk  in  1  system clock; the memory write clock is tied to it.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- base_addr  in  ADDR_W  first word address; sampled on start.
- in_valid  in  1  byte available from the host link.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both 1.
- dado  out  DATA_W  word to memory.
- endereco  out  ADDR_W  memory address.
- write  out  1  memory write enable; high for one cycle per word.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky load-failure flag; cleared by the next start.
- words_loaded  out  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-load abandons the load immediately. Any word already written stays in memory, and no write is issued on the reset cycle.
- Stream format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then N words of 4 bytes each, most-significant byte first (byte0 = dado[31:24]).
- FSM states:
  - IDLE: in_ready=0. On start: latch base_addr, clear error and words_loaded, set busy=1, go to CNT_LO.
  - CNT_LO: in_ready=1. On transfer, store the low byte, go to CNT_HI.
  - CNT_HI: in_ready=1. On transfer, form N, then:
    - N==0 goes to FIN.
    - base_addr+N > DEPTH goes to ERR.
    - Otherwise goes to BYTES with byte index 0.
  - BYTES: in_ready=1. Each transfer shifts the byte into the assembly register. After the 4th byte, go to WR.
  - WR: in_ready=0, write=1 for exactly one cycle, dado=assembled word, endereco=base+words_loaded. The next cycle increments words_loaded and goes to BYTES, or to FIN when words_loaded reaches N.
  - FIN: busy=0, done=1 for one cycle, go to IDLE.
  - ERR: error=1, busy=0, in_ready=0. Stays until start, which restarts exactly as from IDLE.
- Timing:
  - Latency from the 4th byte transfer to write=1 is exactly 1 cycle.
  - dado and endereco are registered and stable for the whole write cycle. The memory captures them on the posedge that ends that cycle.
  - Throughput is at most one word per 5 cycles.
- Invariants:
  - in_valid low simply stalls the FSM in its state. No timeout.
  - start while busy is ignored.
  - write is never asserted outside WR. endereco never exceeds DEPTH-1, so no wrap-around is possible.
  - Bytes offered while in_ready=0 are not consumed.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or right after the count when N==0), one extra CHK byte is expected in a CHK state with in_ready=1.
  - The loader compares it against the XOR of all stream bytes, including the count bytes.
  - Match goes to FIN. Mismatch goes to ERR; already-written words remain.
- Not defined: no CHK state; the FSM goes from the last WR directly to FIN.

Decomposition:
- Shared package holds:
  - the state encoding enum for IDLE, CNT_LO, CNT_HI, BYTES, WR, CHK, FIN, ERR;
  - constants BYTES_PER_WORD=4 and COUNT_BYTES=2.
- One sub-module: loader_word_asm, a byte shift register with a 2-bit index that flags word_full on the 4th byte; it is cleared by the FSM.

Test Plan:
- Basic load: reset, start with base_addr=0, then stream 02 00 04 1F 01 CD 54 00 00 1A.
  - Writes 0x041F01CD @0, then 0x5400001A @1.
  - Each write is 1 cycle after its 4th byte.
  - done pulses once, words_loaded=2.
- Stalls: same stream with in_valid dropped for 3 cycles between every byte. Identical writes, no extra or duplicate writes.
- Overflow: base_addr=126, count=3. Goes to ERR right after COUNT_HI: error=1, write never asserted, in_ready=0.
- Zero count: stream 00 00. done after COUNT_HI with no write (with LOADER_CHECKSUM_EN, done after CHK=00).
- Reset mid-load: reset low after byte 2 of word 1.
  - All outputs 0 next cycle.
  - A following start plus a fresh stream loads correctly.
- Checksum (LOADER_CHECKSUM_EN): basic stream plus correct XOR byte gives done. A wrong byte gives error=1, no done, and both words still written.

Source files
------------

// File: rtl/memoria_loader_pkg.sv
// Shared types and constants for the memoria_loader program-image loader.
// The optional trailing checksum byte is enabled with LOADER_CHECKSUM_EN.
package memoria_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_BYTES,
      S_WR,
      S_CHK,
      S_FIN,
      S_ERR
   } loader_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_BYTES    = 2;
   localparam int COUNT_W        = COUNT_BYTES * 8;

endpackage

// File: rtl/memoria_loader_word_asm.sv
// Byte-to-word assembler: shifts stream bytes in MSB first and flags the
// transfer that completes a word. The FSM holds it cleared outside word fetch.
module loader_word_asm
   import memoria_loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset_n_i,
   input  logic                        clr_i,
   input  logic                        shift_i,
   input  logic [7:0]                  byte_i,
   output logic [BYTES_PER_WORD*8-1:0] word_o,
   output logic                        word_full_o
);

   localparam int KEEP_W = (BYTES_PER_WORD - 1) * 8;

   logic [KEEP_W-1:0]           shreg_q;
   logic [BYTES_PER_WORD*8-1:0] shreg_d;
   logic [1:0]                  idx_q;

   // Lane 0 takes the incoming byte; every other lane takes its lower neighbour.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         if (gi == 0) begin : g_first
            assign shreg_d[7:0] = byte_i;
         end else begin : g_rest
            assign shreg_d[gi*8 +: 8] = shreg_q[(gi-1)*8 +: 8];
         end
      end
   endgenerate

   assign word_o      = shreg_d;
   assign word_full_o = shift_i && (idx_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (!reset_n_i || clr_i) begin
         shreg_q <= '0;
         idx_q   <= '0;
      end else if (shift_i) begin
         shreg_q <= shreg_d[KEEP_W-1:0];
         idx_q   <= idx_q + 2'd1;
      end
   end

endmodule

// File: rtl/memoria_loader.sv
// Streams a count-prefixed byte image from a host link into word memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module memoria_loader
   import memoria_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] dado,
   output logic [ADDR_W-1:0] endereco,
   output logic              write,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   loader_state_e      state_q;
   logic [ADDR_W-1:0]  base_q;
   logic [7:0]         cnt_lo_q;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;
   logic [COUNT_W:0]   end_d;
   logic [ADDR_W:0]    wl_inc_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  word_d;
   logic               last_d;
   logic               xfer;
   logic               shift_en;
   logic               asm_clr;
   logic               word_full;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         chk_q;
`endif

   assign in_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                     (state_q == S_BYTES)  || (state_q == S_CHK);
   assign xfer     = in_valid && in_ready;
   assign shift_en = xfer && (state_q == S_BYTES);
   assign asm_clr  = (state_q != S_BYTES);

   assign count_d  = {in_data, cnt_lo_q};
   // One spare bit so base+N cannot wrap before the bound check.
   assign end_d    = (COUNT_W+1)'(base_q) + (COUNT_W+1)'(count_d);
   assign wl_inc_d = words_loaded + (ADDR_W+1)'(1);
   assign addr_d   = base_q + words_loaded[ADDR_W-1:0];
   assign last_d   = (COUNT_W'(wl_inc_d) == count_q);

   loader_word_asm u_asm (
      .clk         (clk),
      .reset_n_i   (reset),
      .clr_i       (asm_clr),
      .shift_i     (shift_en),
      .byte_i      (in_data),
      .word_o      (word_d),
      .word_full_o (word_full)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         cnt_lo_q     <= '0;
         count_q      <= '0;
         dado         <= '0;
         endereco     <= '0;
         write        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         write <= 1'b0;
         done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         if (xfer) chk_q <= chk_q ^ in_data;
`endif
         case (state_q)
            S_IDLE, S_ERR: begin
               if (start) begin
                  base_q       <= base_addr;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  busy         <= 1'b1;
                  state_q      <= S_CNT_LO;
`ifdef LOADER_CHECKSUM_EN
                  chk_q        <= '0;
`endif
               end
            end
            S_CNT_LO: begin
               if (xfer) begin
                  cnt_lo_q <= in_data;
                  state_q  <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (xfer) begin
                  count_q <= count_d;
                  if (count_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q <= S_CHK;
`else
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= S_FIN;
`endif
                  end else if (end_d > (COUNT_W+1)'(DEPTH)) begin
                     error   <= 1'b1;
                     busy    <= 1'b0;
                     state_q <= S_ERR;
                  end else begin
                     state_q <= S_BYTES;
                  end
               end
            end
            S_BYTES: begin
               if (word_full) begin
                  write    <= 1'b1;
                  dado     <= word_d;
                  endereco <= addr_d;
                  state_q  <= S_WR;
               end
            end
            S_WR: begin
               words_loaded <= wl_inc_d;
               if (last_d) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
`else
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= S_FIN;
`endif
               end else begin
                  state_q <= S_BYTES;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  busy <= 1'b0;
                  if (in_data == chk_q) begin
                     done    <= 1'b1;
                     state_q <= S_FIN;
                  end else begin
                     error   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
`endif
            S_FIN: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memoria_loader.sv
// Self-checking bench for memoria_loader: table of load scenarios plus
// hand-written corner sequences; writes are checked against a scoreboard queue.
module tb_memoria_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  base_addr;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] dado;
   logic [9:0]  endereco;
   logic        write;
   logic        busy;
   logic        done;
   logic        error;
   logic [10:0] words_loaded;

   memoria_loader #(.DATA_W(32), .ADDR_W(10), .DEPTH(128)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .dado         (dado),
      .endereco     (endereco),
      .write        (write),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [9:0] base;
      int         n;
      int         gap;
      bit         fixed;
      bit         bad_chk;
      bit         ovf;
   } vec_t;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   wr_t         exp_q[$];
   wr_t         mon_e;
   vec_t        vecs[9];
   logic [31:0] basic_words[2];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          cyc = 0;
   int          last_xfer_cyc = -100;
   int          done_total = 0;
   int          d0;
   logic [7:0]  xsum;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         chk("ready_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      last_xfer_cyc = cyc;
      xsum ^= b;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_start(input logic [9:0] b);
      base_addr = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = ~b;
   endtask

   task automatic run_load(input string tag, input logic [9:0] base, input int n, input int gap,
                           input bit fixed, input bit bad_chk, input bit ovf);
      logic [31:0] w;
      logic [15:0] n16;
      int          dstart;
      bit          exp_err;
      exp_err = ovf || (CHK_EN && bad_chk);
      n16     = 16'(n);
      dstart  = done_total;
      do_start(base);
      xsum = 8'h00;
      chk({tag, "/busy_start"}, busy, 1);
      send_byte(n16[7:0], gap);
      send_byte(n16[15:8], ovf ? 0 : gap);
      if (ovf) begin
         chk({tag, "/err_flag"}, error, 1);
         chk({tag, "/err_ready"}, in_ready, 0);
         chk({tag, "/err_busy"}, busy, 0);
      end else begin
         for (int i = 0; i < n; i++) begin
            w = fixed ? basic_words[i] : $urandom;
            exp_q.push_back('{addr: base + 10'(i), data: w});
            for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
         end
`ifdef LOADER_CHECKSUM_EN
         send_byte(bad_chk ? ~xsum : xsum, 0);
`endif
      end
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "/done_pulses"}, done_total - dstart, exp_err ? 0 : 1);
      chk({tag, "/words_loaded"}, words_loaded, ovf ? 0 : n);
      chk({tag, "/error"}, error, exp_err);
      chk({tag, "/busy_end"}, busy, 0);
      chk({tag, "/queue_empty"}, exp_q.size(), 0);
      $display("load %s base=%0d n=%0d gap=%0d: words_loaded=%0d error=%0b", tag, base, n, gap,
               words_loaded, error);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got time limit, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; base_addr = '0; xsum = 8'h00;
      basic_words[0] = 32'h041F01CD;
      basic_words[1] = 32'h5400001A;
      vecs[0] = '{base: 10'd0,   n: 2,   gap: 0, fixed: 1'b1, bad_chk: 1'b0, ovf: 1'b0};
      vecs[1] = '{base: 10'd0,   n: 2,   gap: 3, fixed: 1'b1, bad_chk: 1'b0, ovf: 1'b0};
      vecs[2] = '{base: 10'd126, n: 3,   gap: 0, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b1};
      vecs[3] = '{base: 10'd0,   n: 0,   gap: 0, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b0};
      vecs[4] = '{base: 10'd125, n: 3,   gap: 1, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b0};
      vecs[5] = '{base: 10'd127, n: 1,   gap: 0, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b0};
      vecs[6] = '{base: 10'd128, n: 1,   gap: 0, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b1};
      vecs[7] = '{base: 10'd10,  n: 2,   gap: 0, fixed: 1'b1, bad_chk: 1'b1, ovf: 1'b0};
      vecs[8] = '{base: 10'd0,   n: 300, gap: 0, fixed: 1'b0, bad_chk: 1'b0, ovf: 1'b1};

      // Write monitor: every write pops one expected entry and must follow its 4th byte by one cycle.
      fork
         forever begin
            @(negedge clk);
            if (done === 1'b1) done_total++;
            if (write === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", write, 0);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("wr_addr", endereco, mon_e.addr);
                  chk("wr_data", dado, mon_e.data);
                  chk("wr_latency", cyc, last_xfer_cyc);
                  $display("write @%0d data=0x%08h", endereco, dado);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {in_ready, write, busy, done, error, words_loaded, endereco, dado}, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         run_load($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].gap,
                  vecs[i].fixed, vecs[i].bad_chk, vecs[i].ovf);

      // Bytes offered while idle must not be consumed.
      in_valid = 1'b1;
      in_data  = 8'h05;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_ready", in_ready, 0);
      run_load("idle_offer", 10'd3, 1, 1, 1'b0, 1'b0, 1'b0);

      // start while busy is ignored.
      d0 = done_total;
      do_start(10'd20);
      xsum = 8'h00;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      base_addr = 10'd50;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      chk("busy_start/busy", busy, 1);
      exp_q.push_back('{addr: 10'd20, data: 32'hA5C30F71});
      send_byte(8'hA5, 0);
      send_byte(8'hC3, 0);
      send_byte(8'h0F, 0);
      send_byte(8'h71, 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(xsum, 0);
`endif
      repeat (4) @(posedge clk);
      #1;
      chk("busy_start/done_pulses", done_total - d0, 1);
      chk("busy_start/words_loaded", words_loaded, 1);
      chk("busy_start/queue_empty", exp_q.size(), 0);
      $display("load busy_start: words_loaded=%0d", words_loaded);

      // Reset in the middle of the second word.
      do_start(10'd0);
      xsum = 8'h00;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      exp_q.push_back('{addr: 10'd0, data: 32'h11223344});
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midreset_outputs", {in_ready, write, busy, done, error, words_loaded, endereco, dado}, 0);
      chk("midreset_queue", exp_q.size(), 0);
      $display("mid-load reset applied");
      reset = 1'b1;
      @(posedge clk); #1;
      run_load("after_reset", 10'd0, 2, 0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
